// File: rtl/pad_cfg_ctrl.sv
// Bidir pad configuration controller: shadow/active config banks, post-reset safe hold,
// and a registered GPIO/peripheral pad mux with break-before-make OE turnaround.
module pad_cfg_ctrl #(
    parameter int NUM_BIDIR_PADS = 40,
    parameter int HOLD_CYCLES    = 16,
    parameter int TURN_CYCLES    = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_BIDIR_PADS)-1:0] cfg_addr,
    input  logic [7:0]                        cfg_wdata,
    output logic [7:0]                        cfg_rdata,
    output logic                              cfg_rvalid,
    input  logic                              cfg_commit,
    output logic                              cfg_busy,
    input  logic [NUM_BIDIR_PADS-1:0]         periph_out,
    input  logic [NUM_BIDIR_PADS-1:0]         periph_oe,
    output logic [NUM_BIDIR_PADS-1:0]         gpio_in,
    input  logic [NUM_BIDIR_PADS-1:0]         bidir_in,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_out,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0]         bidir_pd
);

    localparam int AW = $clog2(NUM_BIDIR_PADS);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TURN_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES);
    localparam logic [AW:0]   NUM_PADS  = (AW + 1)'(NUM_BIDIR_PADS);
    localparam logic [7:0]    CFG_RST   = 8'h10;

    localparam int B_OUT  = 0;
    localparam int B_OE   = 1;
    localparam int B_CS   = 2;
    localparam int B_SL   = 3;
    localparam int B_IE   = 4;
    localparam int B_PU   = 5;
    localparam int B_PD   = 6;
    localparam int B_FUNC = 7;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [HW-1:0]             r_hold_cnt;

    logic [7:0]                r_shadow     [NUM_BIDIR_PADS];
    logic [7:0]                r_active     [NUM_BIDIR_PADS];
    logic [7:0]                w_shadow_nxt [NUM_BIDIR_PADS];
    logic [TW-1:0]             r_tcnt       [NUM_BIDIR_PADS];
    logic [NUM_BIDIR_PADS-1:0] w_turn_hit;
    logic [NUM_BIDIR_PADS-1:0] w_tcnt_nz;

    logic                      w_run;
    logic                      w_addr_ok;
    logic                      w_acc;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_commit;

    logic [7:0]                r_rdata;
    logic                      r_rvalid;
    logic [NUM_BIDIR_PADS-1:0] r_sync;
    logic [NUM_BIDIR_PADS-1:0] r_gpio_in;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_out;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_oe;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_cs;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_sl;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_ie;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_pu;
    logic [NUM_BIDIR_PADS-1:0] r_bidir_pd;

    assign w_run     = (r_state == S_RUN);
    assign w_addr_ok = ({1'b0, cfg_addr} < NUM_PADS);
    assign w_acc     = cfg_valid && w_run;
    assign w_wr      = w_acc && cfg_we && w_addr_ok;
    assign w_rd      = w_acc && !cfg_we;
    assign w_commit  = cfg_commit && w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_HOLD && r_hold_cnt != HOLD_LAST)
                r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // RUN is terminal; only reset brings the block back to HOLD.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_HOLD;
        endcase
    end

    // A write landing in the commit cycle is folded into the committed image.
    always_comb begin
        w_turn_hit = '0;
        w_tcnt_nz  = '0;
        for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
            w_shadow_nxt[i] = r_shadow[i];
            if (w_wr && cfg_addr == AW'(i))
                w_shadow_nxt[i] = cfg_wdata;
            w_turn_hit[i] = w_commit &&
                ((r_active[i][B_FUNC] != w_shadow_nxt[i][B_FUNC]) ||
                 (!w_shadow_nxt[i][B_FUNC] && (r_active[i][B_OE] != w_shadow_nxt[i][B_OE])));
            w_tcnt_nz[i]  = (r_tcnt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
                r_shadow[i] <= CFG_RST;
                r_active[i] <= CFG_RST;
                r_tcnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
                r_shadow[i] <= w_shadow_nxt[i];
                if (w_commit)
                    r_active[i] <= w_shadow_nxt[i];
                if (w_turn_hit[i])
                    r_tcnt[i] <= TURN_LOAD;
                else if (w_tcnt_nz[i])
                    r_tcnt[i] <= r_tcnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 8'h00;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd)
                r_rdata <= w_addr_ok ? r_active[cfg_addr] : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_gpio_in <= '0;
        end else begin
            r_sync    <= bidir_in;
            r_gpio_in <= r_sync;
        end
    end

    // Pads stay input-only until HOLD expires; OE is blanked while a pad turns around.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bidir_out <= '0;
            r_bidir_oe  <= '0;
            r_bidir_cs  <= '0;
            r_bidir_sl  <= '0;
            r_bidir_ie  <= '1;
            r_bidir_pu  <= '0;
            r_bidir_pd  <= '0;
        end else begin
            for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
                if (!w_run) begin
                    r_bidir_out[i] <= 1'b0;
                    r_bidir_oe[i]  <= 1'b0;
                    r_bidir_cs[i]  <= 1'b0;
                    r_bidir_sl[i]  <= 1'b0;
                    r_bidir_ie[i]  <= 1'b1;
                    r_bidir_pu[i]  <= 1'b0;
                    r_bidir_pd[i]  <= 1'b0;
                end else begin
                    r_bidir_out[i] <= r_active[i][B_FUNC] ? periph_out[i] : r_active[i][B_OUT];
                    r_bidir_oe[i]  <= w_tcnt_nz[i] ? 1'b0 :
                                      (r_active[i][B_FUNC] ? periph_oe[i] : r_active[i][B_OE]);
                    r_bidir_cs[i]  <= r_active[i][B_CS];
                    r_bidir_sl[i]  <= r_active[i][B_SL];
                    r_bidir_ie[i]  <= r_active[i][B_IE];
                    r_bidir_pu[i]  <= r_active[i][B_PU];
                    r_bidir_pd[i]  <= r_active[i][B_PD] && !r_active[i][B_PU];
                end
            end
        end
    end

    assign cfg_ready  = w_run;
    assign cfg_busy   = !w_run || (|w_tcnt_nz);
    assign cfg_rdata  = r_rdata;
    assign cfg_rvalid = r_rvalid;
    assign gpio_in    = r_gpio_in;
    assign bidir_out  = r_bidir_out;
    assign bidir_oe   = r_bidir_oe;
    assign bidir_cs   = r_bidir_cs;
    assign bidir_sl   = r_bidir_sl;
    assign bidir_ie   = r_bidir_ie;
    assign bidir_pu   = r_bidir_pu;
    assign bidir_pd   = r_bidir_pd;

endmodule
